// File: rtl/slurm16_reset_pkg.sv
// Shared types for the slurm16 reset sequencer:
// sequencer states, reset-cause codes and counter sizing.
package slurm16_reset_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2,
        ST_SW_HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/slurm16_sync2.sv
// Two-flop synchroniser with asynchronous reset to RESET_VAL;
// used for the PLL lock input and for reset deassertion.
module slurm16_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/slurm16_reset_seq.sv
// PLL-lock driven reset sequencer for the slurm16 core and peripherals.
// Optional watchdog: define SLURM16_RESET_SEQ_WDT_EN.
module slurm16_reset_seq
    import slurm16_reset_pkg::*;
#(
    parameter int LOCK_STABLE = 1024,
    parameter int HOLD_CYCLES = 10000,
    parameter int SW_PULSE    = 16,
    parameter int WDT_CYCLES  = 25125000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCK,
    input  logic       SW_RST_REQ,
    input  logic       WDT_KICK,
    output logic       CORE_RSTb,
    output logic       PERIPH_RSTb,
    output logic [1:0] RST_CAUSE,
    output logic       BUSY
);

    localparam int LW  = cnt_width(LOCK_STABLE);
    localparam int HW  = cnt_width(HOLD_CYCLES);
    localparam int SWW = cnt_width(SW_PULSE);

    localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCK_STABLE - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  HALF_LAST =
        HW'((HOLD_CYCLES / 2 > 0) ? HOLD_CYCLES / 2 - 1 : 0);
    localparam logic [SWW-1:0] SW_LAST   = SWW'(SW_PULSE - 1);

    logic            rst_int;
    logic            lock_s;
    logic            lost;
    state_t          state;
    logic [LW-1:0]   lock_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [SWW-1:0]  sw_cnt;

`ifdef SLURM16_RESET_SEQ_WDT_EN
    localparam int WW = cnt_width(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
    logic [WW-1:0] wdt_cnt;
`else
    logic unused_wdt;
    assign unused_wdt = WDT_KICK ^ (WDT_CYCLES != 0);
`endif

    // Reset asserts at once, releases two clocks after RST falls.
    slurm16_sync2 #(.RESET_VAL(1'b1)) u_rst_sync (
        .clk (CLK),
        .rst (RST),
        .d   (1'b0),
        .q   (rst_int)
    );

    slurm16_sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk (CLK),
        .rst (rst_int),
        .d   (PLL_LOCK),
        .q   (lock_s)
    );

    assign lost = !lock_s && (state != ST_WAIT_LOCK);

    always_ff @(posedge CLK or posedge rst_int) begin
        if (rst_int) begin
            state       <= ST_WAIT_LOCK;
            CORE_RSTb   <= 1'b0;
            PERIPH_RSTb <= 1'b0;
            RST_CAUSE   <= CAUSE_POR;
            BUSY        <= 1'b1;
            lock_cnt    <= '0;
            hold_cnt    <= '0;
            sw_cnt      <= '0;
`ifdef SLURM16_RESET_SEQ_WDT_EN
            wdt_cnt     <= '0;
`endif
        end else if (lost) begin
            state       <= ST_WAIT_LOCK;
            CORE_RSTb   <= 1'b0;
            PERIPH_RSTb <= 1'b0;
            RST_CAUSE   <= CAUSE_LOCK;
            BUSY        <= 1'b1;
            lock_cnt    <= '0;
        end else begin
            unique case (state)
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HALF_LAST)
                        PERIPH_RSTb <= 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_RUN;
                        CORE_RSTb   <= 1'b1;
                        PERIPH_RSTb <= 1'b1;
                        BUSY        <= 1'b0;
`ifdef SLURM16_RESET_SEQ_WDT_EN
                        wdt_cnt     <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_RUN: begin
`ifdef SLURM16_RESET_SEQ_WDT_EN
                    if (WDT_KICK)
                        wdt_cnt <= '0;
                    else if (wdt_cnt != WDT_LAST)
                        wdt_cnt <= wdt_cnt + WW'(1);
                    // A kick in the expiry cycle wins.
                    if (!WDT_KICK && wdt_cnt == WDT_LAST) begin
                        state       <= ST_HOLD;
                        CORE_RSTb   <= 1'b0;
                        PERIPH_RSTb <= 1'b0;
                        BUSY        <= 1'b1;
                        RST_CAUSE   <= CAUSE_WDT;
                        hold_cnt    <= '0;
                    end else
`endif
                    if (SW_RST_REQ) begin
                        state     <= ST_SW_HOLD;
                        CORE_RSTb <= 1'b0;
                        BUSY      <= 1'b1;
                        RST_CAUSE <= CAUSE_SW;
                        sw_cnt    <= '0;
                    end
                end
                ST_SW_HOLD: begin
                    if (sw_cnt == SW_LAST) begin
                        state     <= ST_RUN;
                        CORE_RSTb <= 1'b1;
                        BUSY      <= 1'b0;
`ifdef SLURM16_RESET_SEQ_WDT_EN
                        wdt_cnt   <= '0;
`endif
                    end else begin
                        sw_cnt <= sw_cnt + SWW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slurm16_reset_seq.sv
// Directed bench for slurm16_reset_seq with a cycle-level reference
// model of the sequencing rules and hand-computed timing checks.
module tb_slurm16_reset_seq;

    localparam int LS = 4;
    localparam int HC = 10;
    localparam int SP = 3;
    localparam int WC = 20;
`ifdef SLURM16_RESET_SEQ_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RST;
    logic       PLL_LOCK;
    logic       SW_RST_REQ;
    logic       WDT_KICK;
    logic       CORE_RSTb;
    logic       PERIPH_RSTb;
    logic [1:0] RST_CAUSE;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    slurm16_reset_seq #(
        .LOCK_STABLE (LS),
        .HOLD_CYCLES (HC),
        .SW_PULSE    (SP),
        .WDT_CYCLES  (WC)
    ) dut (
        .CLK         (clk),
        .RST         (RST),
        .PLL_LOCK    (PLL_LOCK),
        .SW_RST_REQ  (SW_RST_REQ),
        .WDT_KICK    (WDT_KICK),
        .CORE_RSTb   (CORE_RSTb),
        .PERIPH_RSTb (PERIPH_RSTb),
        .RST_CAUSE   (RST_CAUSE),
        .BUSY        (BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 waiting, 1 holding, 2 running, 3 sw pulse.
    int         m_mode = 0;
    int         m_run = 0;
    int         m_t = 0;
    int         m_wd = 0;
    int         m_nwd = 0;
    int         m_rel = 0;
    logic       m_h0 = 1'b0;
    logic       m_h1 = 1'b0;
    logic       m_lk = 1'b0;
    logic [1:0] m_cause = 2'b00;

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            m_mode = 0; m_run = 0; m_t = 0; m_wd = 0; m_rel = 0;
            m_h0 = 1'b0; m_h1 = 1'b0; m_cause = 2'b00;
        end else if (m_rel < 2) begin
            m_rel++;
        end else begin
            // lock seen by the sequencer is the input two edges ago
            m_lk = m_h1;
            m_h1 = m_h0;
            m_h0 = PLL_LOCK;
            if (m_mode != 0 && !m_lk) begin
                m_mode = 0; m_run = 0; m_cause = 2'b01;
            end else begin
                case (m_mode)
                    0: begin
                        m_run = m_lk ? m_run + 1 : 0;
                        if (m_run == LS) begin
                            m_mode = 1; m_t = 0; m_run = 0;
                        end
                    end
                    1: begin
                        m_t++;
                        if (m_t == HC) begin m_mode = 2; m_wd = 0; end
                    end
                    2: begin
                        m_nwd = WDT_KICK ? 0 : m_wd + 1;
                        if (WDT_ON && m_nwd == WC) begin
                            m_mode = 1; m_t = 0; m_cause = 2'b11;
                        end else if (SW_RST_REQ) begin
                            m_mode = 3; m_t = 0; m_cause = 2'b10;
                        end else begin
                            m_wd = m_nwd;
                        end
                    end
                    default: begin
                        m_t++;
                        if (m_t == SP) begin m_mode = 2; m_wd = 0; end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_core", CORE_RSTb, m_mode == 2);
            chk("model_periph", PERIPH_RSTb,
                m_mode >= 2 || (m_mode == 1 && m_t >= HC / 2));
            chk("model_busy", BUSY, m_mode != 2);
            chk("model_cause", RST_CAUSE, m_cause);
        end
    end

    function automatic logic get_out(input int sel);
        case (sel)
            0:       return CORE_RSTb;
            1:       return PERIPH_RSTb;
            default: return BUSY;
        endcase
    endfunction

    // Count falling edges until an output reaches val; 0 means timeout.
    task automatic wait_level(input string name, input int sel,
                              input logic val, input int exp);
        int n;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (get_out(sel) === val) begin
                n = i;
                break;
            end
        end
        chk(name, n, exp);
    endtask

    int first;
    int low;

    initial begin
        RST = 1'b0; PLL_LOCK = 1'b1; SW_RST_REQ = 1'b0; WDT_KICK = 1'b0;
        #1 RST = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("por_core", CORE_RSTb, 0);
        chk("por_periph", PERIPH_RSTb, 0);
        chk("por_busy", BUSY, 1);
        chk("por_cause", RST_CAUSE, 0);

        // Power-on with lock already present.
        RST = 1'b0;
        wait_level("por_periph_rise", 1, 1'b1, 13);
        wait_level("por_core_after_periph", 0, 1'b1, 5);
        chk("por_run_busy", BUSY, 0);
        chk("por_run_cause", RST_CAUSE, 0);

        // Lock loss from RUN.
        PLL_LOCK = 1'b0;
        repeat (4) @(negedge clk);
        chk("loss_cause", RST_CAUSE, 1);
        chk("loss_periph", PERIPH_RSTb, 0);

        // One-cycle lock glitch after three stable cycles.
        @(negedge clk) PLL_LOCK = 1'b1;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) PLL_LOCK = 1'b0;
            if (n == 4) PLL_LOCK = 1'b1;
            if (PERIPH_RSTb === 1'b1 && first == 0) first = n;
        end
        chk("glitch_periph_rise", first, 15);
        chk("glitch_core", CORE_RSTb, 1);

        // Software reset pulse.
        SW_RST_REQ = 1'b1;
        @(negedge clk) SW_RST_REQ = 1'b0;
        low = (CORE_RSTb === 1'b0) ? 1 : 0;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (CORE_RSTb === 1'b0) low++;
            if (PERIPH_RSTb !== 1'b1) low += 100;
        end
        chk("sw_core_low_cycles", low, 3);
        chk("sw_cause", RST_CAUSE, 2);

        // Lock loss reaches the sequencer together with SW_RST_REQ.
        @(negedge clk) PLL_LOCK = 1'b0;
        @(negedge clk);
        @(negedge clk) SW_RST_REQ = 1'b1;
        @(negedge clk) SW_RST_REQ = 1'b0;
        chk("both_core", CORE_RSTb, 0);
        chk("both_periph", PERIPH_RSTb, 0);
        chk("both_cause", RST_CAUSE, 1);
        chk("both_busy", BUSY, 1);

        // RST asserted in the middle of HOLD.
        @(negedge clk) PLL_LOCK = 1'b1;
        wait_level("relock_periph_rise", 1, 1'b1, 11);
        @(posedge clk);
        #3 RST = 1'b1;
        #1;
        chk("async_core", CORE_RSTb, 0);
        chk("async_periph", PERIPH_RSTb, 0);
        chk("async_busy", BUSY, 1);
        chk("async_cause", RST_CAUSE, 0);
        repeat (2) @(negedge clk);
        RST = 1'b0;
        wait_level("rerun_periph_rise", 1, 1'b1, 13);
        wait_level("rerun_core_after_periph", 0, 1'b1, 5);

`ifdef SLURM16_RESET_SEQ_WDT_EN
        wait_level("wdt_expire", 0, 1'b0, WC);
        chk("wdt_cause", RST_CAUSE, 3);
        chk("wdt_periph", PERIPH_RSTb, 0);
        wait_level("wdt_periph_rise", 1, 1'b1, 5);
        wait_level("wdt_core_rise", 0, 1'b1, 5);
`else
        low = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (CORE_RSTb !== 1'b1) low++;
        end
        chk("nowdt_core_low", low, 0);
        chk("nowdt_cause", RST_CAUSE, 0);
`endif

        // Regular kicks keep the core running.
        low = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            WDT_KICK = (n % 15 == 0);
            if (CORE_RSTb !== 1'b1) low++;
        end
        @(negedge clk) WDT_KICK = 1'b0;
        chk("kick_core_low", low, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/slurm16_reset_seq.md
Name: slurm16_reset_seq

Overview:
Reset sequencer between the iCE40 PLL and the slurm16 core/peripheral fabric. It waits for a stable PLL lock, then releases peripheral reset and core reset in order. It re-sequences on lock loss, software reset request or, optionally, watchdog expiry. It replaces the free-running power-on reset counter at top level and records the cause of the last reset for firmware.

Parameters:
LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before leaving WAIT_LOCK (min 1)
HOLD_CYCLES, 10000, cycles spent in HOLD; peripheral reset is released at HOLD_CYCLES/2 (integer division), core reset at HOLD_CYCLES
SW_PULSE, 16, cycles core reset is held for a software reset (min 1)
WDT_CYCLES, 25125000, watchdog timeout in cycles (used only with the optional feature)

Ports:
CLK  input  1  system clock (PLL output)
RST  input  1  asynchronous, active-high reset; asserts outputs immediately, deassertion synchronised internally (2 flops)
PLL_LOCK  input  1  PLL lock, asynchronous; 2-flop synchronised
SW_RST_REQ  input  1  single-cycle request from the core to reset the core only
WDT_KICK  input  1  single-cycle watchdog reload from the core
CORE_RSTb  output  1  active-low core reset, registered
PERIPH_RSTb  output  1  active-low peripheral reset, registered
RST_CAUSE  output  2  00 power-on, 01 lock loss, 10 software, 11 watchdog
BUSY  output  1  high in every state except RUN

Behaviour:
- Reset (RST high): state=WAIT_LOCK; CORE_RSTb=0, PERIPH_RSTb=0, RST_CAUSE=00, BUSY=1; all counters are 0.
- States: WAIT_LOCK, HOLD, RUN, SW_HOLD.
- WAIT_LOCK: the lock counter increments each cycle the synchronised lock is 1 and clears to 0 on any 0. When the counter reaches LOCK_STABLE-1 with lock still 1, the next state is HOLD and the hold counter is cleared.
- HOLD: the hold counter increments each cycle.
  - PERIPH_RSTb goes to 1 on the cycle after the counter equals HOLD_CYCLES/2-1.
  - CORE_RSTb goes to 1 and the state goes to RUN on the cycle after the counter equals HOLD_CYCLES-1.
  - Lock loss in HOLD: both resets go to 0, state returns to WAIT_LOCK, cause=01.
- RUN: BUSY=0. Events are evaluated each cycle in priority order lock loss > watchdog > software.
  - Lock loss (synchronised lock = 0): next cycle both resets go to 0, state=WAIT_LOCK, cause=01.
  - SW_RST_REQ: next cycle CORE_RSTb=0 while PERIPH_RSTb stays 1; state=SW_HOLD; cause=10.
- SW_HOLD: after SW_PULSE cycles CORE_RSTb=1 and the state returns to RUN. Lock loss here behaves as in RUN.
- SW_RST_REQ and WDT_KICK are ignored outside RUN.
- RST_CAUSE holds its value until the next reset event; it is cleared only by RST.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.
- RST asserted mid-sequence takes effect immediately; no partial state survives.

Optional Feature:
Macro SLURM16_RESET_SEQ_WDT_EN.
- Defined: a watchdog counter loads 0 on entry to RUN and on WDT_KICK, and increments in RUN only. When it reaches WDT_CYCLES-1, next cycle both resets go to 0, cause=11, state=HOLD (the PLL is still locked, so WAIT_LOCK is skipped).
- If WDT_KICK occurs in the same cycle as expiry, the kick wins.
- The counter is frozen in SW_HOLD.
- Not defined: no watchdog logic; WDT_KICK is unused; RST_CAUSE never shows 11.

Decomposition:
- Shared package slurm16_reset_pkg: state encoding constants, RST_CAUSE codes (CAUSE_POR, CAUSE_LOCK, CAUSE_SW, CAUSE_WDT).
- One sub-module, slurm16_sync2: a 2-flop synchroniser, instanced for PLL_LOCK and for RST deassertion.

Test Plan:
- LOCK_STABLE=4, HOLD_CYCLES=10. Release RST, raise PLL_LOCK → PERIPH_RSTb rises 5 HOLD cycles before CORE_RSTb; BUSY falls with CORE_RSTb; RST_CAUSE=00.
- Glitch lock low for 1 cycle after 3 stable cycles → the lock counter restarts and HOLD entry is delayed by the full LOCK_STABLE.
- In RUN, pulse SW_RST_REQ with SW_PULSE=3 → CORE_RSTb low for exactly 3 cycles, PERIPH_RSTb stays 1, RST_CAUSE=10.
- In RUN, drop PLL_LOCK in the same cycle as SW_RST_REQ → both resets low, state WAIT_LOCK, RST_CAUSE=01.
- With WDT_EN and WDT_CYCLES=20, no kicks → at cycle 20 both resets go low, RST_CAUSE=11, resequence through HOLD. Kicks every 15 cycles → no reset.
- Assert RST mid-HOLD → both outputs go to 0 the same cycle (asynchronously); after release the sequence restarts from WAIT_LOCK.
